// File: rtl/multi_chan_reader.sv
// Multi-channel frame reader: on a frame-complete edge, streams a frame header,
// then a header plus samples for every enabled channel, through a 2-entry output queue.
module multi_chan_reader #(
    parameter int NCH = 4,
    parameter int DW  = 32,
    parameter int AW  = 10,
    parameter int LW  = 11,
    parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_complete,
    input  logic [NCH-1:0]    i_ch_en,
    input  logic [NCH*LW-1:0] i_len,
    input  logic [NCH*DW-1:0] i_rd_data,
    output logic [AW-1:0]     o_rd_addr,
    output logic [CW-1:0]     o_rd_ch,
    output logic [DW-1:0]     o_out_data,
    output logic              o_out_vld,
    output logic              o_out_last,
    input  logic              i_out_rdy,
    output logic              o_busy,
    output logic [15:0]       o_frame_cnt,
    output logic              o_overrun,
    input  logic              i_clr_ovr
);

    typedef enum logic [2:0] {S_IDLE, S_FHDR, S_CHDR, S_DATA, S_DRAIN} state_e;

    localparam logic [LW-1:0] MAXLEN = LW'(1) << AW;

    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
        return (l > MAXLEN) ? MAXLEN : l;
    endfunction

    state_e         state_q, state_d;
    logic           cmp_q;
    logic [15:0]    cnt_q, cnt_d;
    logic           ovr_q, ovr_d;
    logic [NCH-1:0] en_q;
    logic [LW-1:0]  len_q [NCH];
    logic [CW-1:0]  ch_q, ch_d;
    logic [LW-1:0]  addr_q, addr_d;

    // Single-stage issue pipeline: headers ride it too, so every word lands in the
    // queue exactly one clock after issue and header/data interleave without bubbles.
    logic           pend_vld_q, pend_vld_d;
    logic           pend_hdr_q, pend_hdr_d;
    logic [DW-1:0]  pend_word_q, pend_word_d;
    logic [CW-1:0]  pend_ch_q, pend_ch_d;
    logic           pend_last_q, pend_last_d;

    logic [DW-1:0]  q_data_q [2];
    logic [DW-1:0]  q_data_d [2];
    logic           q_last_q [2];
    logic           q_last_d [2];
    logic [1:0]     occ_q, occ_d;

    logic           start_edge, start, pop, can_issue, last_addr;
    logic [2:0]     fill;
    logic [LW-1:0]  cur_len;
    logic           first_found, next_found;
    logic [CW-1:0]  first_idx, next_idx;
    logic [DW-1:0]  fhdr_word, chdr_word, rd_sel, push_word;

    assign start_edge = i_complete & ~cmp_q;
    assign start      = start_edge && (state_q == S_IDLE);
    assign pop        = o_out_vld & i_out_rdy;
    assign fill       = {1'b0, occ_q} + {2'b0, pend_vld_q};
    assign can_issue  = (fill - {2'b0, pop}) < 3'd2;
    assign cur_len    = len_q[ch_q];
    assign last_addr  = (addr_q == cur_len - LW'(1));

    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (en_q[i] && !first_found) begin
                first_found = 1'b1;
                first_idx   = CW'(i);
            end
            if (en_q[i] && !next_found && (i > 32'(ch_q))) begin
                next_found = 1'b1;
                next_idx   = CW'(i);
            end
        end
    end

    always_comb begin
        fhdr_word          = '0;
        fhdr_word[31:24]   = 8'hA5;
        fhdr_word[23:16]   = 8'(NCH);
        fhdr_word[15:0]    = cnt_q;
        chdr_word          = '0;
        chdr_word[31:24]   = 8'hC0;
        chdr_word[23:16]   = 8'(ch_q);
        chdr_word[LW-1:0]  = cur_len;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ch_d        = ch_q;
        addr_d      = addr_q;
        pend_vld_d  = 1'b0;
        pend_hdr_d  = 1'b0;
        pend_word_d = '0;
        pend_ch_d   = pend_ch_q;
        pend_last_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = S_FHDR;
                end
            end
            S_FHDR: begin
                if (can_issue) begin
                    pend_vld_d  = 1'b1;
                    pend_hdr_d  = 1'b1;
                    pend_word_d = fhdr_word;
                    if (first_found) begin
                        ch_d    = first_idx;
                        state_d = S_CHDR;
                    end else begin
                        pend_last_d = 1'b1;
                        state_d     = S_DRAIN;
                    end
                end
            end
            S_CHDR: begin
                if (can_issue) begin
                    pend_vld_d  = 1'b1;
                    pend_hdr_d  = 1'b1;
                    pend_word_d = chdr_word;
                    if (cur_len != '0) begin
                        addr_d  = '0;
                        state_d = S_DATA;
                    end else if (next_found) begin
                        ch_d = next_idx;
                    end else begin
                        pend_last_d = 1'b1;
                        state_d     = S_DRAIN;
                    end
                end
            end
            S_DATA: begin
                if (can_issue) begin
                    pend_vld_d = 1'b1;
                    pend_ch_d  = ch_q;
                    addr_d     = addr_q + LW'(1);
                    if (last_addr) begin
                        addr_d = '0;
                        if (next_found) begin
                            ch_d    = next_idx;
                            state_d = S_CHDR;
                        end else begin
                            pend_last_d = 1'b1;
                            state_d     = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (occ_q == 2'd0 && !pend_vld_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ovr_d = ovr_q;
        if (i_clr_ovr) begin
            ovr_d = 1'b0;
        end
        if (start_edge && state_q != S_IDLE) begin
            ovr_d = 1'b1;
        end
    end

    always_comb begin
        rd_sel = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (CW'(i) == pend_ch_q) begin
                rd_sel = i_rd_data[i*DW +: DW];
            end
        end
        push_word = pend_hdr_q ? pend_word_q : rd_sel;
    end

    always_comb begin
        q_data_d = q_data_q;
        q_last_d = q_last_q;
        occ_d    = occ_q;
        case ({pend_vld_q, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    q_data_d[0] = push_word;
                    q_last_d[0] = pend_last_q;
                end else begin
                    q_data_d[1] = push_word;
                    q_last_d[1] = pend_last_q;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                q_data_d[0] = q_data_q[1];
                q_last_d[0] = q_last_q[1];
                occ_d       = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    q_data_d[0] = push_word;
                    q_last_d[0] = pend_last_q;
                end else begin
                    q_data_d[0] = q_data_q[1];
                    q_last_d[0] = q_last_q[1];
                    q_data_d[1] = push_word;
                    q_last_d[1] = pend_last_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cmp_q       <= 1'b0;
            cnt_q       <= '0;
            ovr_q       <= 1'b0;
            en_q        <= '0;
            len_q       <= '{default: '0};
            ch_q        <= '0;
            addr_q      <= '0;
            pend_vld_q  <= 1'b0;
            pend_hdr_q  <= 1'b0;
            pend_word_q <= '0;
            pend_ch_q   <= '0;
            pend_last_q <= 1'b0;
            q_data_q    <= '{default: '0};
            q_last_q    <= '{default: 1'b0};
            occ_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmp_q       <= i_complete;
            cnt_q       <= cnt_d;
            ovr_q       <= ovr_d;
            ch_q        <= ch_d;
            addr_q      <= addr_d;
            pend_vld_q  <= pend_vld_d;
            pend_hdr_q  <= pend_hdr_d;
            pend_word_q <= pend_word_d;
            pend_ch_q   <= pend_ch_d;
            pend_last_q <= pend_last_d;
            q_data_q    <= q_data_d;
            q_last_q    <= q_last_d;
            occ_q       <= occ_d;
            if (start) begin
                en_q <= i_ch_en;
                for (int unsigned k = 0; k < NCH; k++) begin
                    len_q[k] <= clamp_len(i_len[k*LW +: LW]);
                end
            end
        end
    end

    assign o_rd_addr   = addr_q[AW-1:0];
    assign o_rd_ch     = ch_q;
    assign o_out_data  = q_data_q[0];
    assign o_out_vld   = (occ_q != 2'd0);
    assign o_out_last  = o_out_vld & q_last_q[0];
    assign o_busy      = (state_q != S_IDLE);
    assign o_frame_cnt = cnt_q;
    assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_multi_chan_reader.sv
// Bench for multi_chan_reader: builds each frame's expected word list from the
// enable mask and lengths, then scoreboards every stream transfer against it.
module tb_multi_chan_reader;

    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int AW  = 10;
    localparam int LW  = 11;
    localparam int CW  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_complete = 1'b0;
    logic [NCH-1:0]    i_ch_en = '0;
    logic [NCH*LW-1:0] i_len = '0;
    logic [NCH*DW-1:0] rd_data = '0;
    logic [AW-1:0]     o_rd_addr;
    logic [CW-1:0]     o_rd_ch;
    logic [DW-1:0]     o_out_data;
    logic              o_out_vld;
    logic              o_out_last;
    logic              i_out_rdy = 1'b1;
    logic              o_busy;
    logic [15:0]       o_frame_cnt;
    logic              o_overrun;
    logic              i_clr_ovr = 1'b0;

    multi_chan_reader #(.NCH(NCH), .DW(DW), .AW(AW), .LW(LW), .CW(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_complete  (i_complete),
        .i_ch_en     (i_ch_en),
        .i_len       (i_len),
        .i_rd_data   (rd_data),
        .o_rd_addr   (o_rd_addr),
        .o_rd_ch     (o_rd_ch),
        .o_out_data  (o_out_data),
        .o_out_vld   (o_out_vld),
        .o_out_last  (o_out_last),
        .i_out_rdy   (i_out_rdy),
        .o_busy      (o_busy),
        .o_frame_cnt (o_frame_cnt),
        .o_overrun   (o_overrun),
        .i_clr_ovr   (i_clr_ovr)
    );

    always #5 clk = ~clk;

    int unsigned  n_vec = 0;
    int unsigned  n_err = 0;
    int           cyc = 0;
    logic [DW:0]  exp_q [$];
    logic [15:0]  cnt_m = '0;
    logic [7:0]   salt = '0;
    int           rdy_mode = 0;
    bit           first_flag = 1'b0;
    int           first_xfer = 0;
    int           last_xfer = 0;
    int           nwords_m = 0;
    bit           prev_stall = 1'b0;
    logic [DW+1:0] prev_word = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(input int k, input int a, input logic [7:0] s);
        return {8'hD0 ^ 8'(k), s, 16'(a)};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Buffer model: registered read, one clock of latency, all channels in parallel.
    always @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            rd_data[k*DW +: DW] <= mem_word(k, int'(o_rd_addr), salt);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       i_out_rdy = 1'b1;
                1:       i_out_rdy = ~i_out_rdy;
                default: i_out_rdy = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold", 64'({o_out_vld, o_out_last, o_out_data}), 64'(prev_word));
                end
                if (o_out_vld && i_out_rdy) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_word", 64'({1'b1, o_out_last, o_out_data}), 64'd0);
                    end else begin
                        chk("word", 64'({o_out_last, o_out_data}), 64'(exp_q.pop_front()));
                    end
                    if (first_flag) begin
                        first_xfer = cyc;
                        first_flag = 1'b0;
                    end
                    last_xfer = cyc;
                end
                prev_stall = o_out_vld && !i_out_rdy;
                prev_word  = {1'b1, o_out_last, o_out_data};
            end
        end
    end

    task automatic check_reset_vals();
        chk("rst_addr", 64'(o_rd_addr), 64'd0);
        chk("rst_ch",   64'(o_rd_ch), 64'd0);
        chk("rst_data", 64'(o_out_data), 64'd0);
        chk("rst_vld",  64'(o_out_vld), 64'd0);
        chk("rst_last", 64'(o_out_last), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_cnt",  64'(o_frame_cnt), 64'd0);
        chk("rst_ovr",  64'(o_overrun), 64'd0);
    endtask

    task automatic build_and_start(input logic [NCH-1:0] en, input logic [NCH*LW-1:0] lens);
        int l;
        salt      = 8'($urandom);
        i_ch_en   = en;
        i_len     = lens;
        cnt_m     = cnt_m + 16'd1;
        exp_q.push_back({1'b0, 8'hA5, 8'(NCH), cnt_m});
        for (int k = 0; k < NCH; k++) begin
            if (en[k]) begin
                l = int'(lens[k*LW +: LW]);
                if (l > (1 << AW)) l = 1 << AW;
                exp_q.push_back({1'b0, 8'hC0, 8'(k), 5'b0, 11'(l)});
                for (int a = 0; a < l; a++) exp_q.push_back({1'b0, mem_word(k, a, salt)});
            end
        end
        exp_q[exp_q.size()-1][DW] = 1'b1;
        nwords_m   = exp_q.size();
        first_flag = 1'b1;
        @(posedge clk);
        #1 i_complete = 1'b1;
        @(posedge clk);
        #1 i_complete = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("hdr_not_early", 64'(o_out_vld), 64'd0);
        @(negedge clk);
        chk("hdr_latency", 64'(o_out_vld), 64'd1);
        chk("busy_latency", 64'(o_busy), 64'd1);
    endtask

    task automatic wait_done(input bit gapchk);
        int fall;
        fall = -1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (!o_busy) begin
                fall = cyc;
                break;
            end
        end
        if (fall < 0) chk("busy_timeout", 64'(o_busy), 64'd0);
        else          chk("busy_fall", 64'(fall), 64'(last_xfer + 2));
        chk("leftover", 64'(exp_q.size()), 64'd0);
        chk("frame_cnt", 64'(o_frame_cnt), 64'(cnt_m));
        if (gapchk) chk("no_gap", 64'(last_xfer - first_xfer), 64'(nwords_m - 1));
    endtask

    function automatic logic [NCH*LW-1:0] rand_lens(input int maxl);
        logic [NCH*LW-1:0] r;
        for (int k = 0; k < NCH; k++) r[k*LW +: LW] = LW'($urandom_range(0, maxl));
        return r;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1);
    end

    initial begin
        int m;
        repeat (3) @(posedge clk);
        #1 check_reset_vals();
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        rdy_mode = 0;
        build_and_start(4'b1111, {11'd1, 11'd2, 11'd0, 11'd3});
        wait_done(1'b1);

        rdy_mode = 1;
        build_and_start(4'b0101, {4{11'd4}});
        wait_done(1'b0);

        rdy_mode = 0;
        build_and_start(4'b0000, rand_lens(12));
        wait_done(1'b1);

        rdy_mode = 2;
        build_and_start(4'b0001, {11'd0, 11'd0, 11'd0, 11'd1029});
        wait_done(1'b0);

        // Second edge mid-frame, coinciding with a clear, plus changed inputs.
        rdy_mode = 2;
        build_and_start(4'b0001, {11'd0, 11'd0, 11'd0, 11'd40});
        repeat (3) @(posedge clk);
        #1;
        i_complete = 1'b1;
        i_clr_ovr  = 1'b1;
        i_ch_en    = NCH'($urandom);
        i_len      = rand_lens(2047);
        @(posedge clk);
        #1;
        i_complete = 1'b0;
        i_clr_ovr  = 1'b0;
        @(negedge clk);
        chk("ovr_set_wins", 64'(o_overrun), 64'd1);
        wait_done(1'b0);
        chk("ovr_sticky", 64'(o_overrun), 64'd1);
        @(posedge clk);
        #1 i_clr_ovr = 1'b1;
        @(posedge clk);
        #1 i_clr_ovr = 1'b0;
        @(negedge clk);
        chk("ovr_clr", 64'(o_overrun), 64'd0);

        for (int n = 0; n < 6; n++) begin
            m = int'($urandom_range(0, 2));
            rdy_mode = m;
            build_and_start(NCH'($urandom), rand_lens(12));
            wait_done(m == 0);
        end

        rdy_mode = 0;
        build_and_start(4'b1111, {4{11'd30}});
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_vals();
        exp_q.delete();
        cnt_m = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        build_and_start(4'b1011, {11'd2, 11'd0, 11'd5, 11'd3});
        wait_done(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
